// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 receiver with clock debounce, frame checker and byte FIFO
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_c,
  input  logic                        ps2_d,
  input  logic                        en,
  input  logic                        rd_en,
  output logic [7:0]                  data_out,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        done_tick,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [FILTER_LEN-1:0] filt;
  logic                  fclk, fclk_d;
  logic                  fall_edge;

  state_t          state, state_n;
  logic [9:0]      sr, sr_n;
  logic [3:0]      bit_cnt, bit_n;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic            push, pop;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  // Debounce: filtered clock only changes once the whole window agrees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt   <= '0;
      fclk   <= 1'b0;
      fclk_d <= 1'b0;
    end else begin
      filt <= {filt[FILTER_LEN-2:0], ps2_c};
      if (&filt)
        fclk <= 1'b1;
      else if (~|filt)
        fclk <= 1'b0;
      fclk_d <= fclk;
    end
  end

  assign fall_edge = fclk_d & ~fclk;

  // Frame state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      tcnt    <= '0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      bit_cnt <= bit_n;
      tcnt    <= tcnt_n;
    end
  end

  // Next-state, frame capture and one-cycle status pulses.
  always_comb begin
    state_n    = state;
    sr_n       = sr;
    bit_n      = bit_cnt;
    tcnt_n     = tcnt;
    done_tick  = 1'b0;
    parity_err = 1'b0;
    frame_err  = 1'b0;
    overflow   = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        tcnt_n = '0;
        bit_n  = '0;
        if (fall_edge && en && !ps2_d) begin
          state_n = SHIFT;
          sr_n    = '0;
        end
      end
      SHIFT: begin
        if (fall_edge) begin
          // LSB-first: after ten samples sr = {stop, parity, d7..d0}.
          sr_n   = {ps2_d, sr[9:1]};
          tcnt_n = '0;
          if (bit_cnt == 4'd9) begin
            state_n = CHECK;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end else if (tcnt == TO_LAST) begin
          state_n   = IDLE;
          frame_err = 1'b1;
          sr_n      = '0;
          tcnt_n    = '0;
          bit_n     = '0;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      CHECK: begin
        state_n = IDLE;
        if (!sr[9])
          frame_err = 1'b1;
        else if (!(^sr[8:0]))
          parity_err = 1'b1;
        else begin
          done_tick = 1'b1;
          if (full)
            overflow = 1'b1;
          else
            push = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop   = rd_en && !empty;
  assign empty = (count == '0);
  assign full  = (count == DEPTH_L);

  // FIFO pointers and occupancy; full is judged on the count before this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Byte storage; contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= sr[7:0];
  end

  assign data_out = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  localparam int FL    = 8;
  localparam int DEPTH = 16;
  localparam int TO    = 300;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst, ps2_c, ps2_d, en, rd_en;
  logic [7:0] data_out;
  logic       empty, full, done_tick, parity_err, frame_err, overflow;
  logic [4:0] count;

  ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2_c(ps2_c), .ps2_d(ps2_d), .en(en), .rd_en(rd_en),
    .data_out(data_out), .empty(empty), .full(full), .count(count),
    .done_tick(done_tick), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
  int b_done, b_perr, b_ferr, b_ovf;
  int ferr_cyc = 0, last_low_cyc = 0;
  int at_cnt = -1, post_cnt = -1, post_data = -1;
  logic prev_done = 1'b0;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] d;
    bit par_ok, stop, en_start, en_mid;
    int e_done, e_perr, e_ferr;
  } vec_t;
  vec_t vecs[8];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (done_tick) begin n_done++; at_cnt = count; end
    if (prev_done) begin post_cnt = count; post_data = data_out; end
    prev_done = done_tick;
    if (parity_err) n_perr++;
    if (frame_err) begin n_ferr++; ferr_cyc = cyc; end
    if (overflow) n_ovf++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input bit par_ok, input bit stop);
    logic p;
    p = par_ok ? ~^d : ^d;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic snap();
    b_done = n_done; b_perr = n_perr; b_ferr = n_ferr; b_ovf = n_ovf;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input logic en_mid);
    for (int i = 0; i < n; i++) begin
      ps2_d = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_c = 1'b0;
      last_low_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_c = 1'b1;
      if (i == 0) en = en_mid;
    end
    ps2_d = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop,
                            input bit en_start, input bit en_mid);
    en = en_start;
    if (en_start && par_ok && stop && q.size() < DEPTH) q.push_back(d);
    send_bits(mk(d, par_ok, stop), 11, en_mid);
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_state(input string name, input int ed, input int ep, input int ef, input int eo);
    chk({name, "_done"}, n_done - b_done, ed);
    chk({name, "_perr"}, n_perr - b_perr, ep);
    chk({name, "_ferr"}, n_ferr - b_ferr, ef);
    chk({name, "_ovf"}, n_ovf - b_ovf, eo);
    chk({name, "_count"}, count, q.size());
    chk({name, "_head"}, data_out, (q.size() != 0) ? q[0] : 8'h00);
  endtask

  task automatic pop_one(input string name);
    chk({name, "_data"}, data_out, (q.size() != 0) ? q[0] : 8'h00);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    chk({name, "_count"}, count, q.size());
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1, 1, 1, 1, 1, 0, 0};
    vecs[1] = '{8'hF0, 0, 1, 1, 1, 0, 1, 0};
    vecs[2] = '{8'hF0, 1, 0, 1, 1, 0, 0, 1};
    vecs[3] = '{8'h55, 1, 1, 0, 0, 0, 0, 0};
    vecs[4] = '{8'hA7, 1, 1, 1, 0, 1, 0, 0};
    vecs[5] = '{8'h00, 1, 1, 1, 1, 1, 0, 0};
    vecs[6] = '{8'hFF, 0, 0, 1, 1, 0, 0, 1};
    vecs[7] = '{8'h80, 1, 1, 1, 1, 1, 0, 0};

    rst = 1'b1; ps2_c = 1'b1; ps2_d = 1'b1; en = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_data", data_out, 0);
    chk("rst_pulses", {done_tick, parity_err, frame_err, overflow}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // First frame: latency of done_tick relative to FIFO update.
    snap();
    send_frame(8'h1C, 1, 1, 1, 1);
    chk_state("lat", 1, 0, 0, 0);
    chk("lat_cnt_at_done", at_cnt, 0);
    chk("lat_cnt_after", post_cnt, 1);
    chk("lat_data_after", post_data, 8'h1C);
    pop_one("lat_pop");
    pop_one("empty_pop");

    // Table of single frames.
    for (int i = 0; i < 8; i++) begin
      snap();
      send_frame(vecs[i].d, vecs[i].par_ok, vecs[i].stop, vecs[i].en_start, vecs[i].en_mid);
      en = 1'b1;
      chk_state($sformatf("vec%0d", i), vecs[i].e_done, vecs[i].e_perr, vecs[i].e_ferr, 0);
    end
    while (q.size() != 0) pop_one("vec_drain");

    // Push and pop in the same cycle with a partially filled FIFO.
    send_frame(8'h11, 1, 1, 1, 1);
    send_frame(8'h22, 1, 1, 1, 1);
    snap();
    fork
      send_frame(8'h33, 1, 1, 1, 1);
      begin
        int w = 0;
        while (!done_tick && w < 2000) begin @(negedge clk); w++; end
        chk("pp_seen", done_tick, 1);
        chk("pp_head", data_out, 8'h11);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        void'(q.pop_front());
        chk("pp_count", count, 2);
      end
    join
    chk_state("pp", 1, 0, 0, 0);
    while (q.size() != 0) pop_one("pp_drain");

    // Fill past capacity.
    snap();
    for (int i = 1; i <= 17; i++) begin
      send_frame(8'(i), 1, 1, 1, 1);
      if (i == 16) chk("ovf_full16", full, 1);
    end
    chk_state("ovf", 17, 0, 0, 1);
    chk("ovf_full", full, 1);
    for (int i = 0; i < 16; i++) pop_one($sformatf("ovf_pop%0d", i));
    chk("ovf_empty", empty, 1);

    // Short glitches on ps2_c must not start a frame.
    snap();
    ps2_d = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ps2_c = 1'b0;
      repeat (FL - 1) @(negedge clk);
      ps2_c = 1'b1;
      repeat (FL + 2) @(negedge clk);
    end
    ps2_d = 1'b1;
    chk_state("glitch_quiet", 0, 0, 0, 0);
    send_frame(8'h3A, 1, 1, 1, 1);
    chk_state("glitch_frame", 1, 0, 0, 0);

    // Inter-edge timeout after five bits.
    snap();
    send_bits(mk(8'hC5, 1, 1), 5, 1'b1);
    repeat (TO + 100) @(negedge clk);
    chk_state("to", 0, 0, 1, 0);
    begin
      int diff;
      diff = ferr_cyc - last_low_cyc - (FL + 1);
      total++;
      if (diff < TO - 1 || diff > TO + 1) begin
        bad++;
        $display("FAIL to_delay: got %0d cycles expected about %0d", diff, TO);
      end
    end
    snap();
    send_frame(8'h1C, 1, 1, 1, 1);
    chk_state("to_next", 1, 0, 0, 0);

    // Reset in the middle of a frame.
    send_bits(mk(8'h5A, 1, 1), 5, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_pulses", {done_tick, parity_err, frame_err, overflow}, 0);
    q.delete();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    snap();
    send_frame(8'h1C, 1, 1, 1, 1);
    chk_state("post_rst", 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  FILTER_LEN, 8, ps2_c debounce window in clk cycles (2..16).
  FIFO_DEPTH, 16, received-byte buffer depth (power of 2, 2..256).
  TIMEOUT_CYC, 100000, max clk cycles between falling edges inside a frame.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  system clock, all logic on rising edge.
  rst  in  1  reset, asynchronous, active-high.
  ps2_c  in  1  raw PS/2 clock line.
  ps2_d  in  1  raw PS/2 data line.
  en  in  1  frame-start enable.
  rd_en  in  1  pop head byte from FIFO.
  data_out  out  8  FIFO head byte (first-word fall-through).
  empty  out  1  FIFO holds 0 bytes.
  full  out  1  FIFO holds FIFO_DEPTH bytes.
  count  out  $clog2(FIFO_DEPTH)+1  bytes held.
  done_tick  out  1  one-cycle pulse, valid frame received.
  parity_err  out  1  one-cycle pulse, odd-parity failure.
  frame_err  out  1  one-cycle pulse, bad stop bit or timeout.
  overflow  out  1  one-cycle pulse, valid byte dropped because FIFO full.

Function
REQ-003 Filter SHALL shift ps2_c into a FILTER_LEN-bit register each cycle; filtered clock goes 1 when all bits are 1, goes 0 when all bits are 0, otherwise holds.
REQ-004 fall_edge SHALL be 1 for exactly one cycle when the filtered clock goes from 1 to 0; ps2_d SHALL be sampled in that cycle.
REQ-005 Frame format SHALL be 11 bits: start(0), d0..d7 LSB first, parity, stop(1); parity is odd over d0..d7 plus the parity bit.
REQ-006 FSM states SHALL be IDLE, SHIFT, CHECK.
REQ-007 IDLE -> SHIFT on fall_edge with en=1 and ps2_d=0; with ps2_d=1 or en=0, the edge SHALL be ignored.
REQ-008 SHIFT SHALL capture the next 10 fall_edge samples; the 10th sample SHALL move the FSM to CHECK.
REQ-009 en SHALL gate only frame start; deasserting en during SHIFT SHALL NOT abort the frame.
REQ-010 In SHIFT, a cycle counter SHALL clear on each fall_edge; reaching TIMEOUT_CYC-1 SHALL return the FSM to IDLE, discard partial data, and pulse frame_err.
REQ-011 CHECK SHALL last one cycle and then return to IDLE.
REQ-012 In CHECK, if stop=0, frame_err SHALL pulse; otherwise, if parity fails, parity_err SHALL pulse; otherwise the frame is valid.
REQ-013 A valid frame SHALL pulse done_tick in the CHECK cycle, and SHALL also push d0..d7 into the FIFO if full=0; if full=1, overflow SHALL pulse and the byte SHALL be dropped.
REQ-014 The full test SHALL use the pre-cycle count; a push while full SHALL be dropped even if rd_en=1 in the same cycle.
REQ-015 Latency: stop-bit fall_edge in cycle N -> CHECK and done_tick in N+1 -> empty=0, count updated and data_out valid in N+2.
REQ-016 rd_en with empty=1 SHALL be ignored; a push and a pop in the same cycle with 0<count<FIFO_DEPTH SHALL leave count unchanged.
REQ-017 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or underflow.
REQ-018 data_out SHALL be 8'h00 when empty=1.

Reset
REQ-019 rst=1 SHALL immediately force: FSM=IDLE, filter register and filtered clock=0, shift register=0, bit and timeout counters=0, FIFO pointers and count=0, empty=1, full=0, data_out=8'h00, all pulse outputs=0.
REQ-020 Reset mid-frame SHALL discard the partial frame; after release, the first frame SHALL be accepted only on a new start bit.

Verification
REQ-021 Send 0x1C (parity 0, stop 1) with en=1 -> done_tick one pulse, count=1, data_out=8'h1C two cycles after the stop edge.
REQ-022 Send 0xF0 with parity 0 -> parity_err pulse, no push, count unchanged; send 0xF0 with parity 1, stop 0 -> frame_err only.
REQ-023 Send FIFO_DEPTH+1 valid bytes 0x01..0x11 without reads -> full=1 after 16, overflow pulse on 17th; pop all 16 -> data 0x01..0x10 in order, then empty=1.
REQ-024 Stop ps2_c after 5 bits -> frame_err pulse TIMEOUT_CYC cycles after the last edge, FSM=IDLE; next full 0x1C frame received correctly.
REQ-025 Glitch ps2_c low for FILTER_LEN-1 cycles -> no fall_edge; with en=0, send a frame -> no capture; assert rst mid-frame -> all outputs at reset values.
